gf3m_digit_mult: RTL and testbench
==================================

// Module: gf3m_digit_mult
// PURPOSE
//  Parametrised digit-serial GF(3^M) multiplier: C = A*B mod p(x), p(x) = x^M + x^K + 2.
//  Successor to the fixed 97-trit, externally sequenced processing element.
//  Owns its sequencing: internal FSM, valid/ready handshakes, D trits of B per cycle, MSB-first Horner.
//  Sits under the pairing controller as the field multiplier; M, K and D are build-time choices.
// PARAMETERS
//  M     97  field degree (trits per element); element width W = 2*M bits
//  K     12  middle tap of p(x); 0 < K < M
//  D     3   trits of B consumed per cycle; 1 <= D <= M
//  (derived) NCYC = ceil(M/D) compute cycles; B zero-padded to D*NCYC trits at top
// PORTS
//  clk        in   1  clock, all state on posedge
//  reset      in   1  synchronous, active-low: reset==0 at posedge clears all state
//  in_valid   in   1  operands a/b (and addend) valid
//  in_ready   out  1  block accepts operands (high only in IDLE)
//  a          in   W  operand A, trit i in bits [2i+1:2i]
//  b          in   W  operand B, same encoding
//  addend     in   W  GF3M_MAC_EN only: value added to product
//  out_valid  out  1  c holds a result
//  out_ready  in   1  consumer takes c
//  c          out  W  result, trit encoding as a
// BEHAVIOUR
//  Trit encoding: 00=0, 01=1, 10=2; input 11 treated as 0; c never contains 11.
//  Reset: state IDLE, in_ready=1, out_valid=0, c=0, accumulator and counter = 0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1; in_valid&in_ready: latch A, B(, addend), acc=0, cnt=0, go RUN.
//   RUN: per cycle apply D Horner steps, highest unconsumed trit first:
//        acc = (acc*x mod p) + A*b_j, with x^M == 2x^K + 1; cnt++.
//        At cnt==NCYC-1 (MAC: also add addend) -> DONE. in_ready=0.
//   DONE: out_valid=1; c stable until out_valid&out_ready, then IDLE next cycle.
//  Latency: accept at edge 0 -> out_valid high after edge NCYC (33 for defaults).
//  Throughput: one op per NCYC+2 cycles min; no accept in same cycle as output handoff.
//  in_valid while not IDLE: ignored, operands unchanged. out_ready outside DONE: ignored.
//  reset low mid-RUN/DONE: next cycle IDLE, result discarded, c=0, out_valid=0.
//  Padding trits (index >= M) are zero; D=1 gives NCYC=M; D=M gives single-cycle RUN.
//  All arithmetic per-trit mod 3, no carries; c updated only on RUN->DONE transition.
// CONFIGURATION
//  GF3M_MAC_EN defined: addend port present; c = A*B + addend (latched with operands).
//  Not defined: no addend port; c = A*B. Latency identical either way.
// STRUCTURE
//  Package gf3m_pkg: TRIT_W=2, trit codes T0/T1/T2, functions trit_add, trit_mul,
//   elem_add (W-wide), elem_mul_x_mod (parametrised by M,K).
//  Sub-module gf3m_horner_step: comb, acc_out = acc_in*x mod p + A*digit; D instances chained.
//  Top holds FSM, cnt (clog2(NCYC) bits), operand/acc registers.
// TESTING (defaults M=97 K=12 D=3 unless noted)
//  A=1, B=1 -> c=1 (trit0=01, rest 0), out_valid first high 33 cycles after accept.
//  A=x^96 (bits[193:192]=01), B=x -> c=2x^12+1 (bits[25:24]=10, bits[1:0]=01).
//  A=2, B=2 -> c=1; A with all trits 11 -> c=0; D=1 and D=97 builds give same results.
//  out_ready low 5 cycles in DONE -> c/out_valid held, in_ready=0, in_valid pulses ignored.
//  reset low at RUN cycle 10 -> next cycle IDLE, in_ready=1, out_valid=0, c=0.
//  GF3M_MAC_EN: A=1, B=1, addend=2 -> c=0; A=0, addend=x^5 -> c=x^5.

Source files
------------

// File: rtl/gf3m_pkg.sv
// Shared definitions for the GF(3^M) digit-serial multiplier.
//  - Trit codes: 00=0, 01=1, 10=2. The code 11 is read as 0 by every helper.
//  - Element helpers work on a fixed maximum-width vector elem_t.
//    Callers zero-extend their M-trit values into elem_t and truncate the result.
//  - The field parameters (m, k) are passed as arguments.
//    At every call site they are elaboration-time constants, so the loops unroll to wiring.
//  - Reduction uses x^m == 2x^k + 1, since p(x) = x^m + x^k + 2 over GF(3).
package gf3m_pkg;

    localparam int TRIT_W = 2;
    localparam int MAX_M  = 256;

    localparam logic [TRIT_W-1:0] T0 = 2'b00;
    localparam logic [TRIT_W-1:0] T1 = 2'b01;
    localparam logic [TRIT_W-1:0] T2 = 2'b10;

    typedef logic [TRIT_W*MAX_M-1:0] elem_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [TRIT_W-1:0] trit_canon(input logic [TRIT_W-1:0] t);
        return (t == 2'b11) ? T0 : t;
    endfunction

    function automatic logic [TRIT_W-1:0] trit_add(input logic [TRIT_W-1:0] x,
                                                   input logic [TRIT_W-1:0] y);
        logic [2:0] s;
        s = {1'b0, trit_canon(x)} + {1'b0, trit_canon(y)};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    // Nonzero trits are +/-1, so the product is 1 when the signs match and 2 otherwise.
    function automatic logic [TRIT_W-1:0] trit_mul(input logic [TRIT_W-1:0] x,
                                                   input logic [TRIT_W-1:0] y);
        logic [TRIT_W-1:0] cx, cy;
        cx = trit_canon(x);
        cy = trit_canon(y);
        if (cx == T0 || cy == T0) return T0;
        return (cx == cy) ? T1 : T2;
    endfunction

    function automatic elem_t elem_add(input elem_t x, input elem_t y);
        elem_t r;
        for (int i = 0; i < MAX_M; i++)
            r[TRIT_W*i +: TRIT_W] = trit_add(x[TRIT_W*i +: TRIT_W], y[TRIT_W*i +: TRIT_W]);
        return r;
    endfunction

    // Multiplies e by x and reduces modulo p(x).
    // Trit m-1 shifts out into x^m, which folds back as 2x^k + 1.
    function automatic elem_t elem_mul_x_mod(input elem_t e, input int m, input int k);
        elem_t             r;
        logic [TRIT_W-1:0] top;
        r   = '0;
        top = trit_canon(e[TRIT_W*(m-1) +: TRIT_W]);
        for (int i = 1; i < MAX_M; i++)
            if (i < m) r[TRIT_W*i +: TRIT_W] = trit_canon(e[TRIT_W*(i-1) +: TRIT_W]);
        r[TRIT_W-1:0]        = top;
        r[TRIT_W*k +: TRIT_W] = trit_add(r[TRIT_W*k +: TRIT_W], trit_mul(top, T2));
        return r;
    endfunction

endpackage

// File: rtl/gf3m_horner_step.sv
// One combinational Horner step of the digit-serial multiplier:
//     acc_out = acc_in * x mod p(x) + a * digit
// Ports:
//     acc_in   in   2*M  running accumulator
//     a        in   2*M  operand A (11 trits read as 0)
//     digit    in   2    current trit of B
//     acc_out  out  2*M  updated accumulator (canonical trits only)
module gf3m_horner_step
    import gf3m_pkg::*;
#(
    parameter int M = 97,
    parameter int K = 12
) (
    input  logic [2*M-1:0] acc_in,
    input  logic [2*M-1:0] a,
    input  logic [1:0]     digit,
    output logic [2*M-1:0] acc_out
);

    localparam int W = 2*M;

    logic [W-1:0] shifted;
    logic [W-1:0] prod;

    assign shifted = W'(elem_mul_x_mod(elem_t'(acc_in), M, K));

    for (genvar gi = 0; gi < M; gi++) begin : g_scale
        assign prod[2*gi +: 2] = trit_mul(a[2*gi +: 2], digit);
    end

    assign acc_out = W'(elem_add(elem_t'(shifted), elem_t'(prod)));

endmodule

// File: rtl/gf3m_digit_mult.sv
// Digit-serial GF(3^M) multiplier, C = A*B mod (x^M + x^K + 2).
// B is consumed most-significant trit first, D trits per cycle (Horner).
// The result is ready NCYC = ceil(M/D) cycles after the operands are accepted.
//
// Optional macro GF3M_MAC_EN:
//     Adds an addend port; the result becomes c = A*B + addend.
//     The addend is latched together with A and B.
//
// Ports:
//     clk        in   1    clock
//     reset      in   1    synchronous, active-low
//     in_valid   in   1    a/b (and addend) valid
//     in_ready   out  1    high only while idle
//     a, b       in   2*M  operands, trit i in bits [2i+1:2i]
//     addend     in   2*M  GF3M_MAC_EN only
//     out_valid  out  1    c holds a result
//     out_ready  in   1    consumer takes c
//     c          out  2*M  result
module gf3m_digit_mult
    import gf3m_pkg::*;
#(
    parameter int M = 97,
    parameter int K = 12,
    parameter int D = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*M-1:0] a,
    input  logic [2*M-1:0] b,
`ifdef GF3M_MAC_EN
    input  logic [2*M-1:0] addend,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*M-1:0] c
);

    localparam int W     = 2*M;
    localparam int NCYC  = (M + D - 1) / D;
    localparam int BP    = 2*D*NCYC;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

    state_t           state_reg, state_next;
    logic [W-1:0]     a_reg;
    logic [BP-1:0]    b_reg;      // B zero-padded at the top; shifted left as digits are used
    logic [W-1:0]     acc_reg;
    logic [W-1:0]     c_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             last_cycle;
    logic [W-1:0]     acc_chain [0:D];
    logic [W-1:0]     c_next;
`ifdef GF3M_MAC_EN
    logic [W-1:0]     addend_reg;
`endif

    assign last_cycle = (cnt_reg == CNT_W'(NCYC - 1));

    // The D steps of one cycle chain combinationally.
    // The top of b_reg always holds the highest unconsumed trit.
    assign acc_chain[0] = acc_reg;
    for (genvar gi = 0; gi < D; gi++) begin : g_step
        gf3m_horner_step #(.M(M), .K(K)) u_step (
            .acc_in  (acc_chain[gi]),
            .a       (a_reg),
            .digit   (b_reg[BP-1-2*gi -: 2]),
            .acc_out (acc_chain[gi+1])
        );
    end

`ifdef GF3M_MAC_EN
    assign c_next = W'(elem_add(elem_t'(acc_chain[D]), elem_t'(addend_reg)));
`else
    assign c_next = acc_chain[D];
`endif

    always_ff @(posedge clk) begin
        if (!reset) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (last_cycle) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            acc_reg    <= '0;
            c_reg      <= '0;
            cnt_reg    <= '0;
`ifdef GF3M_MAC_EN
            addend_reg <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg      <= a;
                        b_reg      <= BP'(b);
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
`ifdef GF3M_MAC_EN
                        addend_reg <= addend;
`endif
                    end
                end
                ST_RUN: begin
                    acc_reg <= acc_chain[D];
                    b_reg   <= b_reg << (2*D);
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (last_cycle) c_reg <= c_next;
                end
                default: ;
            endcase
        end
    end

    assign c = c_reg;

endmodule

// File: tb/tb_gf3m_digit_mult.sv
module tb_gf3m_digit_mult;

    localparam int M    = 97;
    localparam int K    = 12;
    localparam int D    = 3;
    localparam int W    = 2*M;
    localparam int NCYC = (M + D - 1) / D;

    logic         clk       = 1'b0;
    logic         reset     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
`ifdef GF3M_MAC_EN
    logic [W-1:0] addend    = '0;
`endif
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] c;

    int           n_vec = 0;
    int           n_mis = 0;
    logic [W-1:0] sb_q [$];

    always #5 clk = ~clk;

    gf3m_digit_mult #(.M(M), .K(K), .D(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef GF3M_MAC_EN
        .addend    (addend),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] trit_vec(input int idx, input logic [1:0] v);
        logic [W-1:0] r;
        r = '0;
        r[2*idx +: 2] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] rand_elem();
        logic [W-1:0] r;
        for (int i = 0; i < M; i++) r[2*i +: 2] = 2'($urandom_range(0, 3));
        return r;
    endfunction

    // Reference: schoolbook product, then top-down reduction with x^M = 2x^K + 1.
    function automatic logic [W-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic [W-1:0] adv);
        int pa [M];
        int pb [M];
        int pad[M];
        int pr [2*M-1];
        logic [W-1:0] r;
        for (int i = 0; i < M; i++) begin
            pa[i]  = (av[2*i +: 2]  == 2'b11) ? 0 : int'(av[2*i +: 2]);
            pb[i]  = (bv[2*i +: 2]  == 2'b11) ? 0 : int'(bv[2*i +: 2]);
            pad[i] = (adv[2*i +: 2] == 2'b11) ? 0 : int'(adv[2*i +: 2]);
        end
        for (int i = 0; i < 2*M-1; i++) pr[i] = 0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                pr[i+j] = (pr[i+j] + pa[i]*pb[j]) % 3;
        for (int d = 2*M-2; d >= M; d--) begin
            pr[d-M+K] = (pr[d-M+K] + 2*pr[d]) % 3;
            pr[d-M]   = (pr[d-M] + pr[d]) % 3;
        end
        for (int i = 0; i < M; i++) r[2*i +: 2] = 2'((pr[i] + pad[i]) % 3);
        return r;
    endfunction

    // Drives one operation, measures latency and compares against the scoreboard.
    // With hold set, the consumer stalls 5 cycles in DONE while new operands are offered.
    task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] adv, input bit hold);
        int           cyc;
        logic [W-1:0] exp;
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_bit({tag, "_in_ready_idle"}, in_ready, 1'b1);
        a        = av;
        b        = bv;
`ifdef GF3M_MAC_EN
        addend   = adv;
`endif
        in_valid = 1'b1;
        sb_q.push_back(model(av, bv, adv));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_bit({tag, "_in_ready_run"}, in_ready, 1'b0);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, W'(cyc), W'(NCYC));
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                in_valid = 1'b1;
                a        = rand_elem();
                b        = rand_elem();
                @(posedge clk); #1;
                check_bit({tag, "_hold_valid"}, out_valid, 1'b1);
                check_bit({tag, "_hold_in_ready"}, in_ready, 1'b0);
                check({tag, "_hold_c"}, c, exp);
            end
            in_valid = 1'b0;
        end
        check({tag, "_c"}, c, exp);
        $display("op %s: a=%h b=%h c=%h exp=%h", tag, av, bv, c, exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_bit({tag, "_out_valid_clr"}, out_valid, 1'b0);
        check_bit({tag, "_back_idle"}, in_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] all11;
        logic [W-1:0] exp_c;
        logic [W-1:0] r1;
        int           cyc;

        all11 = '1;

        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_in_ready", in_ready, 1'b1);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check("reset_c", c, '0);
        reset = 1'b1;
        @(posedge clk); #1;

        do_op("one_x_one", trit_vec(0, 2'b01), trit_vec(0, 2'b01), '0, 1'b0);
        check("one_x_one_const", c, trit_vec(0, 2'b01));

        do_op("x96_x_x", trit_vec(96, 2'b01), trit_vec(1, 2'b01), '0, 1'b0);
        exp_c = trit_vec(K, 2'b10) | trit_vec(0, 2'b01);
        check("x96_x_x_const", c, exp_c);

        do_op("two_x_two", trit_vec(0, 2'b10), trit_vec(0, 2'b10), '0, 1'b0);
        check("two_x_two_const", c, trit_vec(0, 2'b01));

        do_op("all11_a", all11, rand_elem(), '0, 1'b0);
        check("all11_a_const", c, '0);

        r1 = rand_elem();
        do_op("ident", trit_vec(0, 2'b01), r1, '0, 1'b0);

        for (int i = 0; i < 4; i++)
            do_op($sformatf("rand%0d", i), rand_elem(), rand_elem(), '0, 1'b0);

        do_op("hold", rand_elem(), rand_elem(), '0, 1'b1);
        do_op("after_hold", rand_elem(), rand_elem(), '0, 1'b0);

`ifdef GF3M_MAC_EN
        do_op("mac_one", trit_vec(0, 2'b01), trit_vec(0, 2'b01), trit_vec(0, 2'b10), 1'b0);
        check("mac_one_const", c, '0);
        do_op("mac_zero", '0, rand_elem(), trit_vec(5, 2'b01), 1'b0);
        check("mac_zero_const", c, trit_vec(5, 2'b01));
`endif

        // Abort mid-computation with reset; nothing is pushed for this operation.
        a        = rand_elem();
        b        = rand_elem();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_bit("abort_running", in_ready, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check_bit("abort_in_ready", in_ready, 1'b1);
        check_bit("abort_out_valid", out_valid, 1'b0);
        check("abort_c", c, '0);
        $display("op abort: in_ready=%b out_valid=%b c=%h", in_ready, out_valid, c);
        cyc = 0;
        while (cyc < NCYC + 5) begin
            @(posedge clk); #1;
            if (out_valid) break;
            cyc++;
        end
        check_bit("abort_no_result", out_valid, 1'b0);

        do_op("post_abort", rand_elem(), rand_elem(), '0, 1'b0);

        check("scoreboard_empty", W'(sb_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
